// File: rtl/sw_cond_pkg.sv
// Shared constants and helpers for the switch conditioning front end.
package sw_cond_pkg;

    localparam int DB_CYCLES_DEFAULT = 50000;
    localparam int CAP_CNT_W         = 8;

    function automatic int db_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/db_filter.sv
// Single-bit conditioner: 2-flop synchronizer followed by a consecutive-sample
// debounce counter that accepts a new level after DB_CYCLES differing samples.
module db_filter
    import sw_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int               CNT_W  = db_cnt_w(DB_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_d;
    logic [CNT_W-1:0] r_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
            r_c  <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            // Any sample matching the stable level restarts the window.
            if (r_s2 == r_d) begin
                r_c <= '0;
            end else if (r_c == C_LAST) begin
                r_d <= r_s2;
                r_c <= '0;
            end else begin
                r_c <= r_c + C_ONE;
            end
        end
    end

    assign level = r_d;

endmodule

// File: rtl/sw_debounce_latch.sv
// Switch front end for the priority encoder: debounces all inputs, optionally
// freezes a captured snapshot of {en, sw}, and reports change and capture count.
module sw_debounce_latch
    import sw_cond_pkg::*;
#(
    parameter int N_SW      = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SW-1:0]      sw_raw,
    input  logic                 en_raw,
    input  logic                 hold_raw,
    input  logic                 btn_raw,
    output logic [N_SW-1:0]      x,
    output logic                 en,
    output logic                 chg,
    output logic [CAP_CNT_W-1:0] cap_cnt
);

    localparam int N_IN = N_SW + 3;

    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] w_lvl;
    logic [N_SW:0]   w_live;
    logic [N_SW:0]   w_out_next;
    logic            w_hold_d;
    logic            w_btn_d;
    logic            w_cap_edge;

    logic                 r_btn_q;
    logic [N_SW:0]        r_snap;
    logic [N_SW:0]        r_out;
    logic                 r_chg;
    logic [CAP_CNT_W-1:0] r_cap_cnt;

    assign w_raw = {btn_raw, hold_raw, en_raw, sw_raw};

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
        db_filter #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (w_raw[gi]),
            .level (w_lvl[gi])
        );
    end

    assign w_live     = w_lvl[N_SW:0];
    assign w_hold_d   = w_lvl[N_SW+1];
    assign w_btn_d    = w_lvl[N_SW+2];
    assign w_cap_edge = w_btn_d & ~r_btn_q;
    assign w_out_next = w_hold_d ? r_snap : w_live;

    // Snapshot tracks live while not holding, so entering hold freezes the last live word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q   <= 1'b0;
            r_snap    <= '0;
            r_cap_cnt <= '0;
            r_out     <= '0;
            r_chg     <= 1'b0;
        end else begin
            r_btn_q <= w_btn_d;
            if (!w_hold_d) begin
                r_snap <= w_live;
            end else if (w_cap_edge) begin
                r_snap    <= w_live;
                r_cap_cnt <= r_cap_cnt + CAP_CNT_W'(1);
            end
            r_out <= w_out_next;
            r_chg <= (w_out_next != r_out);
        end
    end

    assign x       = r_out[N_SW-1:0];
    assign en      = r_out[N_SW];
    assign chg     = r_chg;
    assign cap_cnt = r_cap_cnt;

endmodule

// File: tb/tb_sw_debounce_latch.sv
// Directed bench for sw_debounce_latch with DB_CYCLES=4: settle, glitch, bounce,
// hold/capture, counter wrap and asynchronous reset.
module tb_sw_debounce_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_raw;
    logic       en_raw;
    logic       hold_raw;
    logic       btn_raw;
    logic [7:0] x;
    logic       en;
    logic       chg;
    logic [7:0] cap_cnt;

    int total = 0;
    int bad   = 0;
    int nchg;

    sw_debounce_latch #(
        .N_SW      (8),
        .DB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .en_raw   (en_raw),
        .hold_raw (hold_raw),
        .btn_raw  (btn_raw),
        .x        (x),
        .en       (en),
        .chg      (chg),
        .cap_cnt  (cap_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture_pulse(input int hi, input int lo);
        btn_raw = 1'b1;
        tick(hi);
        btn_raw = 1'b0;
        tick(lo);
    endtask

    initial begin
        // 1. Reset and settle
        rst_n    = 1'b0;
        sw_raw   = 8'hFF;
        en_raw   = 1'b1;
        hold_raw = 1'b1;
        btn_raw  = 1'b1;
        tick(5);
        chk("rst_x",   {24'h0, x},       32'h0);
        chk("rst_en",  {31'h0, en},      32'h0);
        chk("rst_chg", {31'h0, chg},     32'h0);
        chk("rst_cap", {24'h0, cap_cnt}, 32'h0);
        rst_n    = 1'b1;
        sw_raw   = 8'hA5;
        en_raw   = 1'b1;
        hold_raw = 1'b0;
        btn_raw  = 1'b0;
        tick(6);                       // after edge k+5
        chk("settle_x_early", {24'h0, x},   32'h0);
        chk("settle_chg_early", {31'h0, chg}, 32'h0);
        tick(1);                       // after edge k+6
        chk("settle_x",   {24'h0, x},   32'hA5);
        chk("settle_en",  {31'h0, en},  32'h1);
        chk("settle_chg", {31'h0, chg}, 32'h1);
        tick(1);
        chk("settle_chg_off", {31'h0, chg}, 32'h0);

        // 2. Glitch rejection: 3-cycle pulse on bit 3
        nchg   = 0;
        sw_raw = 8'hAD;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (i == 2) sw_raw = 8'hA5;
            if (chg) nchg++;
        end
        chk("glitch3_x",   {24'h0, x}, 32'hA5);
        chk("glitch3_chg", nchg,       0);

        // 2b. 4-cycle pulse is accepted, then released 4 cycles later
        nchg   = 0;
        sw_raw = 8'hAD;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (i == 3) sw_raw = 8'hA5;
            if (chg) nchg++;
            if (i == 5)  chk("pulse4_x_pre",  {24'h0, x}, 32'hA5);
            if (i == 6)  chk("pulse4_x_rise", {24'h0, x}, 32'hAD);
            if (i == 9)  chk("pulse4_x_hold", {24'h0, x}, 32'hAD);
            if (i == 10) chk("pulse4_x_fall", {24'h0, x}, 32'hA5);
        end
        chk("pulse4_chg", nchg, 2);

        // 3. Bounce on bit 0
        sw_raw = 8'hA4;
        tick(10);
        chk("bounce_pre", {24'h0, x}, 32'hA4);
        for (int i = 0; i < 20; i++) begin
            sw_raw[0] = ((i / 2) % 2 == 0);
            tick(1);
            chk("bounce_x", {24'h0, x}, 32'hA4);
        end
        sw_raw = 8'hA5;
        tick(6);
        chk("bounce_x_early", {24'h0, x}, 32'hA4);
        tick(1);
        chk("bounce_x_final", {24'h0, x}, 32'hA5);

        // 4. Hold and capture
        sw_raw = 8'h12;
        tick(8);
        chk("hold_pre_x", {24'h0, x}, 32'h12);
        hold_raw = 1'b1;
        tick(8);
        chk("hold_enter_x", {24'h0, x}, 32'h12);
        sw_raw = 8'h34;
        tick(10);
        chk("hold_frozen_x", {24'h0, x}, 32'h12);
        chk("hold_frozen_cap", {24'h0, cap_cnt}, 32'h0);
        capture_pulse(10, 10);
        chk("capture_x",   {24'h0, x},       32'h34);
        chk("capture_en",  {31'h0, en},      32'h1);
        chk("capture_cap", {24'h0, cap_cnt}, 32'h1);

        // 5. Release, ignored captures, wrap
        hold_raw = 1'b0;
        tick(8);
        chk("release_x",   {24'h0, x},       32'h34);
        chk("release_cap", {24'h0, cap_cnt}, 32'h1);
        sw_raw = 8'h56;
        tick(8);
        chk("track_x", {24'h0, x}, 32'h56);
        capture_pulse(6, 6);
        capture_pulse(6, 6);
        chk("nohold_cap", {24'h0, cap_cnt}, 32'h1);
        chk("nohold_x",   {24'h0, x},       32'h56);
        hold_raw = 1'b1;
        tick(8);
        for (int i = 0; i < 256; i++) begin
            capture_pulse(7, 7);
            if (i == 253) chk("wrap_254", {24'h0, cap_cnt}, 32'hFF);
            if (i == 254) chk("wrap_255", {24'h0, cap_cnt}, 32'h00);
        end
        chk("wrap_256", {24'h0, cap_cnt}, 32'h01);
        chk("wrap_x",   {24'h0, x},       32'h56);

        // 6. Reset while a debounce count is at 3 with hold active
        sw_raw = 8'h57;
        tick(5);                       // bit 0 counter now at 3
        chk("mid_hold_x", {24'h0, x}, 32'h56);
        rst_n    = 1'b0;
        hold_raw = 1'b0;
        #1;
        chk("async_x",   {24'h0, x},       32'h0);
        chk("async_en",  {31'h0, en},      32'h0);
        chk("async_chg", {31'h0, chg},     32'h0);
        chk("async_cap", {24'h0, cap_cnt}, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_x_early", {24'h0, x}, 32'h0);
        tick(1);
        chk("post_rst_x",   {24'h0, x},   32'h57);
        chk("post_rst_en",  {31'h0, en},  32'h1);
        chk("post_rst_chg", {31'h0, chg}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
